// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues word fetches to instruction memory, holds one
// fetched instruction for decode, and handles redirects by draining an
// in-flight request before fetching from the new target.
module fetch_unit (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instr,
    output logic [31:0] pc_out,
    output logic [31:0] pcplus4,
    output logic        valid
);

    localparam int unsigned XLEN = 32;

    localparam logic [1:0] FETCH = 2'd0;
    localparam logic [1:0] FULL  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]      r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_drain_addr;
    logic [XLEN-1:0] r_instr;
    logic [XLEN-1:0] r_pc_out;
    logic [XLEN-1:0] r_pcplus4;
    logic            r_valid;

    logic [1:0]      w_state_nxt;
    logic [XLEN-1:0] w_pc_nxt;
    logic [XLEN-1:0] w_drain_addr_nxt;
    logic [XLEN-1:0] w_instr_nxt;
    logic [XLEN-1:0] w_pc_out_nxt;
    logic [XLEN-1:0] w_pcplus4_nxt;
    logic            w_valid_nxt;
    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] w_pc_inc;

    // Redirect targets are always word aligned; pc increment wraps mod 2^32.
    assign w_target = redirect_pc & ~XLEN'(32'h3);
    assign w_pc_inc = r_pc + XLEN'(4);

    // State and datapath registers, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= FETCH;
            r_pc         <= '0;
            r_drain_addr <= '0;
            r_instr      <= '0;
            r_pc_out     <= '0;
            r_pcplus4    <= '0;
            r_valid      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_drain_addr <= w_drain_addr_nxt;
            r_instr      <= w_instr_nxt;
            r_pc_out     <= w_pc_out_nxt;
            r_pcplus4    <= w_pcplus4_nxt;
            r_valid      <= w_valid_nxt;
        end
    end

    // Next-state and datapath update rules for each FSM state.
    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_drain_addr_nxt = r_drain_addr;
        w_instr_nxt      = r_instr;
        w_pc_out_nxt     = r_pc_out;
        w_pcplus4_nxt    = r_pcplus4;
        w_valid_nxt      = r_valid;

        case (r_state)
            FETCH: begin
                if (imem_ack) begin
                    if (redirect) begin
                        // Returned word belongs to the abandoned path.
                        w_pc_nxt = w_target;
                    end else begin
                        w_instr_nxt   = imem_rdata;
                        w_pc_out_nxt  = r_pc;
                        w_pcplus4_nxt = w_pc_inc;
                        w_valid_nxt   = 1'b1;
                        w_pc_nxt      = w_pc_inc;
                        w_state_nxt   = FULL;
                    end
                end else if (redirect) begin
                    // Request still outstanding: remember it so it can be drained.
                    w_drain_addr_nxt = r_pc;
                    w_pc_nxt         = w_target;
                    w_state_nxt      = DRAIN;
                end
            end
            FULL: begin
                if (redirect) begin
                    w_valid_nxt = 1'b0;
                    w_pc_nxt    = w_target;
                    w_state_nxt = FETCH;
                end else if (!stall) begin
                    w_valid_nxt = 1'b0;
                    w_state_nxt = FETCH;
                end
            end
            DRAIN: begin
                if (redirect) begin
                    w_pc_nxt = w_target;
                end
                if (imem_ack) begin
                    w_state_nxt = FETCH;
                end
            end
            default: begin
                w_state_nxt = FETCH;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    // Memory request is a pure decode of state; suppressed while in reset.
    assign imem_req  = !reset && (r_state != FULL);
    assign imem_addr = (r_state == DRAIN) ? r_drain_addr : r_pc;

    assign instr   = r_instr;
    assign pc_out  = r_pc_out;
    assign pcplus4 = r_pcplus4;
    assign valid   = r_valid;

endmodule
